// File: rtl/sap_shift_pkg.sv
// rtl/sap_shift_pkg.sv - shared types for the SAP shift register
// Purpose: MODE encodings, control FSM states and datapath select codes.
// Ports: none (package).
package sap_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CPL  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // What the datapath register does on the next enabled edge.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_MODE  = 2'd1,
    SEL_LOAD  = 2'd2,
    SEL_SHIFT = 2'd3
  } sel_t;

endpackage

// File: rtl/sap_shift_ctrl.sv
// rtl/sap_shift_ctrl.sv - serialisation FSM and bit counter
// Purpose: sequences IDLE -> SHIFT -> DONE and tells the datapath whether to
//   apply MODE, load D, shift right with zero fill, or hold.
// Ports:
//   clk_i, clr_i      clock, synchronous active-high reset
//   en_i, start_i     clock enable, serialisation request
//   busy_o, done_o    SHIFT in progress / one-cycle completion pulse
//   sel_o             datapath select (sel_t encoding)
module sap_shift_ctrl
  import sap_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] sel_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sel_t          sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = SEL_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          if (start_i) begin
            sel     = SEL_LOAD;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            sel = SEL_MODE;
          end
        end
      end
      ST_SHIFT: begin
        // The last bit is already on SO: hold it one more cycle, then pulse DONE.
        if (en_i) begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            sel   = SEL_SHIFT;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign done_o = (state_q == ST_DONE);
  assign sel_o  = sel;

endmodule

// File: rtl/sap_shift_reg.sv
// rtl/sap_shift_reg.sv - WIDTH-bit SAP register with shift modes and serialiser
// Purpose: parallel load / shift / rotate / complement / clear register that can
//   also serialise D LSB-first on SO with a BUSY/DONE handshake.
// Ports:
//   CLK, CLR        clock, synchronous active-high reset
//   EN              clock enable (DONE exit ignores it)
//   MODE            parallel operation (mode_t), used only in IDLE
//   D               parallel data
//   SI_L, SI_R      serial-in for right / left shifts
//   START           serialise D request
//   Q               register contents
//   Q_BAR           ~Q, present only when SAP_SHIFT_REG_QBAR_EN is defined
//   SO              serial out, equals Q[0]
//   BUSY, DONE      serialisation status
module sap_shift_reg
  import sap_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_L,
  input  logic             SI_R,
  input  logic             START,
  output logic [WIDTH-1:0] Q,
`ifdef SAP_SHIFT_REG_QBAR_EN
  output logic [WIDTH-1:0] Q_BAR,
`endif
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       sel;

  sap_shift_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk_i   (CLK),
    .clr_i   (CLR),
    .en_i    (EN),
    .start_i (START),
    .busy_o  (BUSY),
    .done_o  (DONE),
    .sel_o   (sel)
  );

  always_comb begin
    q_d = q_q;
    unique case (sel_t'(sel))
      SEL_LOAD:  q_d = D;
      SEL_SHIFT: q_d = {1'b0, q_q[WIDTH-1:1]};
      SEL_MODE: begin
        unique case (mode_t'(MODE))
          MODE_HOLD: q_d = q_q;
          MODE_LOAD: q_d = D;
          MODE_SHL:  q_d = {q_q[WIDTH-2:0], SI_R};
          MODE_SHR:  q_d = {SI_L, q_q[WIDTH-1:1]};
          MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
          MODE_CPL:  q_d = ~q_q;
          MODE_CLR:  q_d = '0;
          default:   q_d = q_q;
        endcase
      end
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign SO = q_q[0];
`ifdef SAP_SHIFT_REG_QBAR_EN
  assign Q_BAR = ~q_q;
`endif

endmodule

// File: tb/tb_sap_shift_reg.sv
// tb/tb_sap_shift_reg.sv - directed self-checking bench for sap_shift_reg
module tb_sap_shift_reg;

  logic        CLK = 1'b0;
  logic        CLR, EN, SI_L, SI_R, START;
  logic [2:0]  MODE;
  logic [31:0] dv;

  logic [7:0]  Q8;
  logic [1:0]  Q2;
  logic [12:0] Q13;
  logic        SO8, SO2, SO13;
  logic        BUSY8, BUSY2, BUSY13;
  logic        DONE8, DONE2, DONE13;
`ifdef SAP_SHIFT_REG_QBAR_EN
  logic [7:0]  QB8;
  logic [1:0]  QB2;
  logic [12:0] QB13;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sap_shift_reg #(.WIDTH(8)) dut8 (
    .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE), .D(dv[7:0]),
    .SI_L(SI_L), .SI_R(SI_R), .START(START), .Q(Q8),
`ifdef SAP_SHIFT_REG_QBAR_EN
    .Q_BAR(QB8),
`endif
    .SO(SO8), .BUSY(BUSY8), .DONE(DONE8)
  );

  sap_shift_reg #(.WIDTH(2)) dut2 (
    .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE), .D(dv[1:0]),
    .SI_L(SI_L), .SI_R(SI_R), .START(START), .Q(Q2),
`ifdef SAP_SHIFT_REG_QBAR_EN
    .Q_BAR(QB2),
`endif
    .SO(SO2), .BUSY(BUSY2), .DONE(DONE2)
  );

  sap_shift_reg #(.WIDTH(13)) dut13 (
    .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE), .D(dv[12:0]),
    .SI_L(SI_L), .SI_R(SI_R), .START(START), .Q(Q13),
`ifdef SAP_SHIFT_REG_QBAR_EN
    .Q_BAR(QB13),
`endif
    .SO(SO13), .BUSY(BUSY13), .DONE(DONE13)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] q_of(input int w);
    case (w)
      2:       return {30'b0, Q2};
      13:      return {19'b0, Q13};
      default: return {24'b0, Q8};
    endcase
  endfunction

  function automatic logic so_of(input int w);
    case (w)
      2:       return SO2;
      13:      return SO13;
      default: return SO8;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      2:       return BUSY2;
      13:      return BUSY13;
      default: return BUSY8;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      2:       return DONE2;
      13:      return DONE13;
      default: return DONE8;
    endcase
  endfunction

  // Serialise d on the WIDTH=w instance; optionally drop EN for stall_n
  // cycles right after bit stall_at appears on SO.
  task automatic ser(input int w, input logic [31:0] d, input int stall_at, input int stall_n);
    logic [31:0] exp_q;
    dv    = d;
    EN    = 1'b1;
    MODE  = 3'b000;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int j = 0; j < w; j++) begin
      chk($sformatf("w%0d so[%0d]", w, j), {31'b0, so_of(w)}, {31'b0, d[j]});
      chk($sformatf("w%0d busy[%0d]", w, j), {31'b0, busy_of(w)}, 32'd1);
      chk($sformatf("w%0d done[%0d]", w, j), {31'b0, done_of(w)}, 32'd0);
      if (j == stall_at) begin
        EN = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk($sformatf("w%0d stall so %0d", w, s), {31'b0, so_of(w)}, {31'b0, d[j]});
          chk($sformatf("w%0d stall busy %0d", w, s), {31'b0, busy_of(w)}, 32'd1);
        end
        EN = 1'b1;
      end
      tick();
    end
    exp_q = (d >> (w - 1)) & 32'd1;
    chk($sformatf("w%0d done pulse", w), {31'b0, done_of(w)}, 32'd1);
    chk($sformatf("w%0d busy at done", w), {31'b0, busy_of(w)}, 32'd0);
    chk($sformatf("w%0d final q", w), q_of(w), exp_q);
    tick();
    chk($sformatf("w%0d done cleared", w), {31'b0, done_of(w)}, 32'd0);
    chk($sformatf("w%0d final q hold", w), q_of(w), exp_q);
    // Let every instance drain before the next test.
    for (int i = 0; i < 16; i++) tick();
  endtask

  initial begin
    CLR = 1'b1; EN = 1'b0; MODE = 3'b000; dv = '0;
    SI_L = 1'b0; SI_R = 1'b0; START = 1'b0;
    tick();
    tick();
    CLR = 1'b0;
    chk("reset q", {24'b0, Q8}, 32'h00);
    chk("reset busy", {31'b0, BUSY8}, 32'd0);
    chk("reset done", {31'b0, DONE8}, 32'd0);
    chk("reset so", {31'b0, SO8}, 32'd0);
`ifdef SAP_SHIFT_REG_QBAR_EN
    chk("reset qbar", {24'b0, QB8}, 32'hFF);
`endif

    // Parallel modes on WIDTH=8.
    EN = 1'b1;
    dv = 32'h96; MODE = 3'b001; tick(); chk("load", {24'b0, Q8}, 32'h96);
    MODE = 3'b100; tick(); chk("rol", {24'b0, Q8}, 32'h2D);
    MODE = 3'b101; tick(); chk("ror", {24'b0, Q8}, 32'h96);
    SI_L = 1'b1; MODE = 3'b011; tick(); chk("shr", {24'b0, Q8}, 32'hCB);
    SI_L = 1'b0;
    dv = 32'h96; MODE = 3'b001; tick();
    SI_R = 1'b0; MODE = 3'b010; tick(); chk("shl", {24'b0, Q8}, 32'h2C);
    dv = 32'h96; MODE = 3'b001; tick();
    MODE = 3'b110; tick(); chk("cpl", {24'b0, Q8}, 32'h69);
    chk("cpl so", {31'b0, SO8}, 32'd1);
`ifdef SAP_SHIFT_REG_QBAR_EN
    chk("cpl qbar", {24'b0, QB8}, 32'h96);
`endif
    EN = 1'b0; dv = 32'h11; MODE = 3'b001; tick(); chk("en low hold", {24'b0, Q8}, 32'h69);
    EN = 1'b1; MODE = 3'b111; tick(); chk("clr mode", {24'b0, Q8}, 32'h00);
    MODE = 3'b000;

    // Serialisation, stall, width sweep.
    ser(8, 32'hB4, -1, 0);
    ser(8, 32'hB4, 3, 3);
    ser(2, 32'h2, -1, 0);
    ser(2, 32'h1, 0, 2);
    ser(13, 32'h1A5B, -1, 0);

    // START beats MODE=clear in IDLE; START/MODE ignored in SHIFT and DONE.
    dv = 32'h5A; MODE = 3'b111; START = 1'b1; tick();
    chk("prio load", {24'b0, Q8}, 32'h5A);
    chk("prio busy", {31'b0, BUSY8}, 32'd1);
    dv = 32'hFF; MODE = 3'b001;
    tick();
    chk("ignore in shift", {24'b0, Q8}, 32'h2D);
    for (int i = 0; i < 6; i++) tick();
    chk("ignore last bit", {24'b0, Q8}, 32'h00);
    tick();
    chk("ignore done", {31'b0, DONE8}, 32'd1);
    chk("ignore done q", {24'b0, Q8}, 32'h00);
    tick();
    chk("start not queued busy", {31'b0, BUSY8}, 32'd0);
    chk("start not queued q", {24'b0, Q8}, 32'h00);
    START = 1'b0; MODE = 3'b000;
    for (int i = 0; i < 16; i++) tick();

    // Reset mid-serialisation aborts without a DONE pulse.
    dv = 32'hA5; START = 1'b1; tick(); START = 1'b0;
    chk("pre-reset q", {24'b0, Q8}, 32'hA5);
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("abort q", {24'b0, Q8}, 32'h00);
    chk("abort busy", {31'b0, BUSY8}, 32'd0);
    chk("abort done", {31'b0, DONE8}, 32'd0);
`ifdef SAP_SHIFT_REG_QBAR_EN
    chk("abort qbar", {24'b0, QB8}, 32'hFF);
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("abort no done %0d", i), {31'b0, DONE8}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_shift_reg.md
# sap_shift_reg

Parametrised general-purpose register for the SAP datapath: synchronous parallel load, shift/rotate/complement/clear modes, and an auto-serialising output sequence with BUSY/DONE handshake. It generalises the single-bit D flip-flop to a WIDTH-bit register. It serves as the accumulator/B/output register and as the serial output port.

## Interface
- WIDTH, default 8: register width in bits; legal range WIDTH >= 2.
- CLK  in  1  rising-edge clock.
- CLR  in  1  synchronous, active-high reset.
- EN  in  1  clock enable. When low, all state holds except the DONE-state exit.
- MODE  in  3  parallel operation select; ignored while BUSY or DONE.
- D  in  WIDTH  parallel load data.
- SI_L  in  1  serial-in bit entering at the MSB on a right shift.
- SI_R  in  1  serial-in bit entering at the LSB on a left shift.
- START  in  1  request to serialise D, LSB first.
- Q  out  WIDTH  register contents.
- Q_BAR  out  WIDTH  bitwise complement of Q. Present only with SAP_SHIFT_REG_QBAR_EN.
- SO  out  1  serial out; always equals Q[0].
- BUSY  out  1  high while serialisation is in progress.
- DONE  out  1  one-cycle pulse after the last bit is presented.

## Operation
- Reset (CLR=1 at a rising edge) overrides everything:
  - Q=0, Q_BAR=all ones, SO=0.
  - BUSY=0, DONE=0, state=IDLE, bit counter=0.
  - Reset mid-serialisation aborts the sequence; no DONE pulse is produced.
- MODE encoding, applied in IDLE when EN=1 and START=0:
  - 000 hold; 001 load (Q<=D).
  - 010 shift left: Q<={Q[WIDTH-2:0],SI_R}.
  - 011 shift right: Q<={SI_L,Q[WIDTH-1:1]}.
  - 100 rotate left; 101 rotate right.
  - 110 complement (Q<=~Q); 111 clear (Q<=0).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: EN=1 and START=1 sets Q<=D, counter<=0, next state SHIFT. START takes priority over MODE.
  - SHIFT, EN=1, counter<WIDTH-1: Q<={1'b0,Q[WIDTH-1:1]}, counter increments.
  - SHIFT, EN=1, counter==WIDTH-1: Q holds, next state DONE.
  - SHIFT, EN=0: Q and counter freeze; BUSY stays high.
  - DONE: exactly one cycle regardless of EN, then IDLE. START and MODE are ignored.
- START is ignored in SHIFT and DONE; it is not queued.
- After a completed sequence, Q={WIDTH-1 zeros, D[WIDTH-1]}.
- Counter width is $clog2(WIDTH). The counter never wraps, because it is compared against WIDTH-1 before incrementing.

## Timing
- Every register updates on the rising edge of CLK; there are no asynchronous paths.
- Q_BAR and SO are combinational from Q.
- Parallel modes have 1-cycle latency: a result requested before edge k is visible after edge k.
- Serialisation with START sampled at edge k and EN held high:
  - After edge k+j, SO=D[j], for j=0..WIDTH-1.
  - BUSY is high from after edge k through edge k+WIDTH.
  - DONE is high in the single cycle after edge k+WIDTH.
  - The earliest next START is accepted at edge k+WIDTH+2.
- Each EN-low cycle during SHIFT stretches the sequence by exactly one cycle.

## Configuration
- The macro is SAP_SHIFT_REG_QBAR_EN.
- Defined: the Q_BAR port exists, equals ~Q, and resets to all ones.
- Undefined: the Q_BAR port and its logic are absent. All other behaviour is identical.

## Structure
- Package sap_shift_pkg holds:
  - the mode_t enum (the 3-bit MODE codes above);
  - the state_t enum (IDLE, SHIFT, DONE).
- Sub-module sap_shift_ctrl holds the FSM plus bit counter. It outputs BUSY, DONE and a load/shift/hold select to the datapath.
- The top level holds the WIDTH-bit datapath register and mode multiplexer.

## Test plan
- Reset: WIDTH=8; drive CLR=1 for one edge from Q=8'hA5 mid-SHIFT -> Q=00, BUSY=0, DONE=0, Q_BAR=FF (with macro).
- Modes: load 8'h96, then:
  - rotate left -> 2D;
  - rotate right -> 96;
  - shift right with SI_L=1 -> CB;
  - shift left with SI_R=0 -> 96;
  - complement -> 69;
  - clear -> 00.
- Serialise: START with D=8'hB4, EN=1 -> SO sequence 0,0,1,0,1,1,0,1 on edges k..k+7; DONE one cycle after edge k+8; final Q=01.
- Stall: same as the Serialise case but with EN=0 for 3 cycles mid-sequence -> bit order unchanged, DONE delayed by exactly 3 cycles, BUSY continuous.
- Priority and ignore:
  - START with MODE=111 in IDLE -> load D, clear not performed.
  - START and MODE=001 during SHIFT/DONE -> no effect on Q or sequence.
- Width sweep: repeat Serialise for WIDTH=2 and WIDTH=13 -> WIDTH bits out, DONE after WIDTH+1 edges, with and without SAP_SHIFT_REG_QBAR_EN.
